// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular-buffer physical register free list with head checkpoints
// Optional duplicate-free detection and sticky dup_err port: FREE_LIST_DUP_CHECK_EN
module phys_reg_free_list #(
  parameter int PHYS_REGS   = 64,
  parameter int ARCH_REGS   = 32,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2,
  parameter int CKPT_DEPTH  = 4,
  parameter int PB          = $clog2(PHYS_REGS),
  parameter int CB          = $clog2(CKPT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ALLOC_WIDTH-1:0]      alloc_req,
  output logic                        alloc_grant,
  output logic [ALLOC_WIDTH*PB-1:0]   alloc_preg,
  input  logic [FREE_WIDTH-1:0]       free_valid,
  input  logic [FREE_WIDTH*PB-1:0]    free_preg,
  input  logic                        ckpt_save,
  input  logic [CB-1:0]               ckpt_id,
  input  logic                        restore,
  input  logic [CB-1:0]               restore_id,
  output logic [PB:0]                 free_count,
  output logic                        empty
`ifdef FREE_LIST_DUP_CHECK_EN
  ,
  output logic                        dup_err
`endif
);

  logic [PB-1:0] list_q    [PHYS_REGS];
  logic [PB-1:0] list_d    [PHYS_REGS];
  logic [PB-1:0] list_init [PHYS_REGS];
  logic [PB:0]   ckpt_q    [CKPT_DEPTH];
  logic [PB:0]   ckpt_d    [CKPT_DEPTH];
  logic [PB:0]   head_q, head_d;
  logic [PB:0]   tail_q, tail_d;
  logic [PB:0]   free_count_q, free_count_d;
  logic [PB:0]   alloc_n;
  logic [PB:0]   wr_off;
  logic [FREE_WIDTH-1:0] free_ok;

  always_comb begin
    alloc_n = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_n = alloc_n + (PB+1)'(alloc_req[i]);
    end
  end

  // Grant is judged on the pre-edge count; same-cycle frees are not bypassed.
  assign alloc_grant = !rst && (alloc_n != '0) && (free_count_q >= alloc_n) && !restore;

  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_preg[i*PB +: PB] = list_q[head_q[PB-1:0] + PB'(i)];
    end
  end

  always_comb begin
    for (int i = 0; i < PHYS_REGS; i++) begin
      list_init[i] = (i < PHYS_REGS - ARCH_REGS) ? PB'(ARCH_REGS + i) : '0;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [PHYS_REGS-1:0] in_list_q, in_list_d, in_list_init;
  logic                 dup_err_q, dup_err_d;
  logic                 dup_hit;
  logic [PB:0]          rb_dist;
  logic [PB-1:0]        rb_rel;

  // A lane is dropped if its preg is already free or an earlier lane carries it.
  always_comb begin
    free_ok = free_valid;
    for (int k = 0; k < FREE_WIDTH; k++) begin
      if (free_valid[k]) begin
        if (in_list_q[free_preg[k*PB +: PB]]) free_ok[k] = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (free_valid[j] && (free_preg[j*PB +: PB] == free_preg[k*PB +: PB])) begin
            free_ok[k] = 1'b0;
          end
        end
      end
    end
    dup_hit = |(free_valid & ~free_ok);
  end

  always_comb begin
    for (int i = 0; i < PHYS_REGS; i++) begin
      in_list_init[i] = (i >= ARCH_REGS);
    end
  end

  always_comb begin
    in_list_d = in_list_q;
    rb_dist   = head_q - ckpt_q[restore_id];
    rb_rel    = '0;
    if (restore) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        rb_rel = PB'(i) - ckpt_q[restore_id][PB-1:0];
        if ({1'b0, rb_rel} < rb_dist) in_list_d[list_q[i]] = 1'b1;
      end
    end else if (alloc_grant) begin
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
        if ((PB+1)'(i) < alloc_n) in_list_d[list_q[head_q[PB-1:0] + PB'(i)]] = 1'b0;
      end
    end
    for (int k = 0; k < FREE_WIDTH; k++) begin
      if (free_ok[k]) in_list_d[free_preg[k*PB +: PB]] = 1'b1;
    end
    dup_err_d = dup_err_q | dup_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_list_q <= in_list_init;
      dup_err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      dup_err_q <= dup_err_d;
    end
  end

  assign dup_err = dup_err_q;
`else
  assign free_ok = free_valid;
`endif

  always_comb begin
    list_d = list_q;
    ckpt_d = ckpt_q;
    head_d = head_q;
    wr_off = '0;
    // Accepted free lanes are packed onto the tail in lane order.
    for (int k = 0; k < FREE_WIDTH; k++) begin
      if (free_ok[k]) begin
        list_d[tail_q[PB-1:0] + wr_off[PB-1:0]] = free_preg[k*PB +: PB];
        wr_off = wr_off + 1'b1;
      end
    end
    tail_d = tail_q + wr_off;
    if (restore) begin
      head_d = ckpt_q[restore_id];
    end else if (alloc_grant) begin
      head_d = head_q + alloc_n;
    end
    if (ckpt_save && !restore) ckpt_d[ckpt_id] = head_d;
    free_count_d = tail_d - head_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      list_q       <= list_init;
      ckpt_q       <= '{default: '0};
      head_q       <= '0;
      tail_q       <= (PB+1)'(PHYS_REGS - ARCH_REGS);
      free_count_q <= (PB+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      list_q       <= list_d;
      ckpt_q       <= ckpt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;
  assign empty      = (free_count_q == '0);

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - directed and random checks of phys_reg_free_list against a queue model
module tb_phys_reg_free_list;
  localparam int PR = 64;
  localparam int AR = 32;
  localparam int AW = 2;
  localparam int FW = 2;
  localparam int CD = 4;
  localparam int PB = 6;
  localparam int CB = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     alloc_req;
  logic              alloc_grant;
  logic [AW*PB-1:0]  alloc_preg;
  logic [FW-1:0]     free_valid;
  logic [FW*PB-1:0]  free_preg;
  logic              ckpt_save;
  logic [CB-1:0]     ckpt_id;
  logic              restore;
  logic [CB-1:0]     restore_id;
  logic [PB:0]       free_count;
  logic              empty;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic              dup_err;
`endif

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_grant(alloc_grant),
    .alloc_preg(alloc_preg), .free_valid(free_valid), .free_preg(free_preg),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .restore(restore), .restore_id(restore_id),
    .free_count(free_count), .empty(empty)
`ifdef FREE_LIST_DUP_CHECK_EN
    , .dup_err(dup_err)
`endif
  );

  int vectors;
  int miscompares;

  // Model: unbounded integer head/tail into a 64-entry ring, pregs outside the list tracked with their allocation position.
  int mem [PR];
  int m_head, m_tail;
  int ckv [CD];
  bit ckok [CD];
  bit in_set [PR];
  bit m_dup;
  int busy_p[$];
  int busy_pos[$];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_head = 0;
    m_tail = PR - AR;
    m_dup  = 1'b0;
    for (int i = 0; i < PR; i++) begin
      mem[i]    = (i < PR - AR) ? AR + i : 0;
      in_set[i] = (i >= AR);
    end
    for (int i = 0; i < CD; i++) begin
      ckv[i]  = 0;
      ckok[i] = 1'b0;
    end
    busy_p.delete();
    busy_pos.delete();
    for (int i = 0; i < AR; i++) begin
      busy_p.push_back(i);
      busy_pos.push_back(-1);
    end
  endtask

  task automatic busy_remove(input int p);
    for (int i = 0; i < busy_p.size(); i++) begin
      if (busy_p[i] == p) begin
        busy_p.delete(i);
        busy_pos.delete(i);
        break;
      end
    end
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] fv, input int fp0, input int fp1,
                      input bit sv, input int sid, input bit rs, input int rid);
    int  cnt, n, old_head, p;
    bit  egrant, acc;
    int  gp [AW];
    int  fps [FW];
    bit  fok [FW];
    alloc_req  = req;
    free_valid = fv;
    free_preg  = {PB'(fp1), PB'(fp0)};
    ckpt_save  = sv;
    ckpt_id    = CB'(sid);
    restore    = rs;
    restore_id = CB'(rid);
    #1;
    cnt    = m_tail - m_head;
    n      = int'(req[0]) + int'(req[1]);
    egrant = (n > 0) && (cnt >= n) && !rs;
    chk("alloc_grant", 32'(alloc_grant), int'(egrant));
    for (int i = 0; i < AW; i++) begin
      gp[i] = mem[(m_head + i) % PR];
      if (cnt > i) chk($sformatf("alloc_preg_lane%0d", i), 32'(alloc_preg[i*PB +: PB]), gp[i]);
    end
    @(posedge clk);
    fps[0] = fp0;
    fps[1] = fp1;
    for (int k = 0; k < FW; k++) begin
      fok[k] = fv[k];
`ifdef FREE_LIST_DUP_CHECK_EN
      if (fv[k] && (in_set[fps[k]] || (k == 1 && fv[0] && fp0 == fp1))) begin
        fok[k] = 1'b0;
        m_dup  = 1'b1;
      end
`endif
    end
    old_head = m_head;
    if (rs) begin
      m_head = ckv[rid];
      for (int j = m_head; j < old_head; j++) in_set[mem[j % PR]] = 1'b1;
      for (int i = busy_p.size() - 1; i >= 0; i--) begin
        if (busy_pos[i] >= m_head) begin
          busy_p.delete(i);
          busy_pos.delete(i);
        end
      end
      for (int i = 0; i < CD; i++) if (ckv[i] > m_head) ckok[i] = 1'b0;
    end else if (egrant) begin
      for (int i = 0; i < n; i++) begin
        in_set[gp[i]] = 1'b0;
        busy_p.push_back(gp[i]);
        busy_pos.push_back(m_head + i);
      end
      m_head = m_head + n;
    end
    for (int k = 0; k < FW; k++) begin
      if (fok[k]) begin
        p = fps[k];
        mem[m_tail % PR] = p;
        m_tail++;
        in_set[p] = 1'b1;
        busy_remove(p);
      end
    end
    if (sv && !rs) begin
      ckv[sid]  = m_head;
      ckok[sid] = 1'b1;
    end
    @(negedge clk);
    chk("free_count", 32'(free_count), m_tail - m_head);
    chk("empty", 32'(empty), int'(m_tail == m_head));
`ifdef FREE_LIST_DUP_CHECK_EN
    chk("dup_err", 32'(dup_err), int'(m_dup));
`endif
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    alloc_req  = 2'b11;
    free_valid = '0;
    free_preg  = '0;
    ckpt_save  = 1'b0;
    ckpt_id    = '0;
    restore    = 1'b0;
    restore_id = '0;
    @(posedge clk);
    #1;
    chk("grant_in_reset", 32'(alloc_grant), 0);
    @(negedge clk);
    rst       = 1'b0;
    alloc_req = '0;
    model_reset();
    #1;
    chk("reset_free_count", 32'(free_count), 32);
    chk("reset_empty", 32'(empty), 0);
    chk("reset_lane0", 32'(alloc_preg[0 +: PB]), 32);
    chk("reset_lane1", 32'(alloc_preg[PB +: PB]), 33);
`ifdef FREE_LIST_DUP_CHECK_EN
    chk("reset_dup_err", 32'(dup_err), 0);
`endif
  endtask

  initial begin
    int r, nf, a, b, minv, rid, ia;
    logic [1:0] req, fv;
    bit sv, rs;
    int elig[$];
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    alloc_req   = '0;
    free_valid  = '0;
    free_preg   = '0;
    ckpt_save   = 1'b0;
    ckpt_id     = '0;
    restore     = 1'b0;
    restore_id  = '0;
    @(negedge clk);
    do_reset();

    for (int c = 0; c < 16; c++) step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("drain_free_count", 32'(free_count), 0);
    chk("drain_empty", 32'(empty), 1);
    step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0);

    step(2'b01, 2'b11, 5, 7, 0, 0, 0, 0);
    chk("nobypass_lane0", 32'(alloc_preg[0 +: PB]), 5);
    chk("nobypass_lane1", 32'(alloc_preg[PB +: PB]), 7);

    do_reset();
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 1, 1, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b11, 2'b01, 3, 0, 0, 0, 1, 1);
    chk("restore_lane0", 32'(alloc_preg[0 +: PB]), 36);
    chk("restore_lane1", 32'(alloc_preg[PB +: PB]), 37);
    chk("restore_free_count", 32'(free_count), 29);

    do_reset();
    for (int c = 0; c < 16; c++) step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) step(2'b00, 2'b11, 2 * c, 2 * c + 1, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("wrap_free_count", 32'(free_count), 0);

`ifdef FREE_LIST_DUP_CHECK_EN
    do_reset();
    step(2'b00, 2'b01, 10, 0, 0, 0, 0, 0);
    step(2'b00, 2'b01, 10, 0, 0, 0, 0, 0);
    chk("dup_count", 32'(free_count), 33);
    step(2'b00, 2'b11, 11, 11, 0, 0, 0, 0);
    chk("dup_lane_count", 32'(free_count), 34);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("dup_sticky", 32'(dup_err), 1);
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom_range(0, 2);
      req = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      minv = 32'h7fffffff;
      for (int i = 0; i < CD; i++) if (ckok[i] && ckv[i] < minv) minv = ckv[i];
      elig.delete();
      for (int i = 0; i < busy_p.size(); i++) if (busy_pos[i] < minv) elig.push_back(busy_p[i]);
      nf = $urandom_range(0, 2);
      if (nf > elig.size()) nf = elig.size();
      a  = 0;
      b  = 0;
      fv = 2'b00;
      if (nf >= 1) begin
        ia = $urandom_range(0, elig.size() - 1);
        a  = elig[ia];
        elig.delete(ia);
        fv = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      end
      if (nf == 2) begin
        b  = elig[$urandom_range(0, elig.size() - 1)];
        fv = 2'b11;
      end
      if (fv == 2'b10) begin
        b = a;
        a = 0;
      end
      rs  = 1'b0;
      rid = 0;
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, CD - 1);
        for (int t = 0; t < CD; t++) begin
          if (!rs && ckok[(r + t) % CD]) begin
            rs  = 1'b1;
            rid = (r + t) % CD;
          end
        end
      end
      sv = ($urandom_range(0, 5) == 0);
      step(req, fv, a, b, sv, $urandom_range(0, CD - 1), rs, rid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Parametrised, N-wide physical register free list for the rename stage of the out-of-order core.
- Allocates up to ALLOC_WIDTH physical registers per cycle, all-or-nothing, in program order.
- Accepts up to FREE_WIDTH freed registers per cycle from commit.
- Keeps CKPT_DEPTH head-pointer checkpoints so a branch mispredict can return all allocations made after the branch in one cycle.

Parameters:
- PHYS_REGS, 64, physical register count; must be a power of two; also the circular-buffer depth.
- ARCH_REGS, 32, architectural registers; pregs 0..ARCH_REGS-1 are mapped at reset and are not in the list.
- ALLOC_WIDTH, 2, allocation lanes per cycle.
- FREE_WIDTH, 2, free lanes per cycle.
- CKPT_DEPTH, 4, number of checkpoint slots.
- PB, $clog2(PHYS_REGS), preg index width.
- CB, $clog2(CKPT_DEPTH), checkpoint id width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  ALLOC_WIDTH  per-lane request; must be contiguous from lane 0 (e.g. 01, 11); a non-contiguous pattern is a caller error.
- alloc_grant  out  1  all requested lanes granted this cycle.
- alloc_preg  out  ALLOC_WIDTH*PB  lane i = list[head+i]; valid whenever free_count > i; lane 0 in the LSBs.
- free_valid  in  FREE_WIDTH  per-lane free; any pattern allowed.
- free_preg  in  FREE_WIDTH*PB  freed preg per lane.
- ckpt_save  in  1  snapshot the head pointer into slot ckpt_id.
- ckpt_id  in  CB  slot to save.
- restore  in  1  roll the head pointer back to slot restore_id.
- restore_id  in  CB  slot to restore.
- free_count  out  PB+1  entries currently free (registered).
- empty  out  1  free_count == 0.
- dup_err  out  1  sticky duplicate-free flag; only present with the optional feature.

Behaviour:
- Storage: circular buffer list[PHYS_REGS] of PB bits. head and tail pointers are PB+1 bits with a wrap bit; indexing uses the low PB bits; count = tail - head, modulo 2^(PB+1).

Reset (rst=1 at an edge, regardless of in-flight activity):
- list[i] = ARCH_REGS+i for i < PHYS_REGS-ARCH_REGS.
- head = 0; tail = PHYS_REGS-ARCH_REGS; free_count = PHYS_REGS-ARCH_REGS.
- All checkpoint slots = 0; dup_err = 0.
- alloc_grant = 0 while rst is high. Reset overrides every other input.

Allocation:
- n = popcount(alloc_req).
- alloc_grant = (n>0) && (free_count >= n) && !restore. Combinational, zero latency; alloc_preg is valid in the same cycle.
- On grant, head += n at the edge.
- Partial grants never occur; on no grant the caller stalls and holds alloc_req.
- Frees arriving in the same cycle are not bypassed: the grant uses pre-edge free_count.

Free:
- Valid lanes are packed in lane order: list[tail + k] = free_preg of the k-th valid lane.
- tail += popcount(free_valid).
- Frees are always accepted, including in restore and grant cycles; overflow cannot occur in a legal machine.

Checkpoint save:
- slot[ckpt_id] = head after this cycle's allocation (head + n if granted, else head).
- The branch's own destination therefore stays allocated after a later restore.
- Saving into an occupied slot overwrites it.

Restore:
- head = slot[restore_id]; no allocation that cycle.
- Frees in the same cycle still apply and tail is unchanged.
- free_count next = tail_next - slot[restore_id].
- restore together with ckpt_save: restore wins and the save is dropped.

Outputs:
- free_count updates each edge: += frees, -= n granted, or recomputed on restore.
- empty is derived from free_count.
- Pointer wrap past index PHYS_REGS-1 is seamless.

Optional Feature:
- Macro: FREE_LIST_DUP_CHECK_EN.
- With it defined:
  - Keep an in_list[PHYS_REGS] bit vector: set on free, cleared on grant.
  - Restore re-sets the bits of the list entries between the restored head and the old head.
  - A free of a preg whose bit is already set, or of the same preg on two lanes in one cycle, is dropped: not written, tail not advanced.
  - That free sets dup_err, which stays 1 until rst.
- Without it: no vector, the dup_err port is absent, and duplicate frees are written unchecked.

Test Plan:
- Reset with defaults -> free_count=32, empty=0, alloc_preg lane0=32 and lane1=33, alloc_grant=0 while rst=1.
- alloc_req=11 for 16 cycles -> pregs 32..63 granted in order, free_count=0, empty=1; a 17th request of 01 -> alloc_grant=0.
- Empty list, free_valid=11 with pregs 5 and 7 while alloc_req=01 in the same cycle -> grant=0; next cycle free_count=2, lane0=5, lane1=7.
- From reset: grant 32/33; next cycle grant 34/35 with ckpt_save=1, ckpt_id=1; grant 36/37; free preg 3 and restore=1, restore_id=1 together -> next cycle lane0=36, lane1=37, free_count=29.
- Allocate all 32, free 40 pregs in the order 0..39 over 20 cycles, then allocate 40 -> tail wraps past 63, pregs are returned in freed order 0..39, free_count returns to 0.
- With FREE_LIST_DUP_CHECK_EN, free preg 10 twice, or on both lanes in one cycle -> free_count rises by 1 only, dup_err=1 and sticky until rst.
